dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: grant -> mem_cs next cycle, done one cycle after mem_ready, abort after TIMEOUT_CYCLES.
// Requesters wait on reqN_done. Define DMEM_ARB_RR_EN for round-robin contention; otherwise req0 has fixed priority.
module dmem_arbiter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_mask,
    output logic        req0_done,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_mask,
    output logic        req1_done,
    output logic        req1_err,
    output logic [31:0] resp_rdata,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, SERVE0 = 2'd1, SERVE1 = 2'd2} state_t;

    // cnt_q holds the number of SERVE cycles already elapsed, so the abort fires in the last allowed one.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [31:0] rdata_q, rdata_d;

    logic serving, any_req, grant1, timeout, complete;

    assign serving  = (state_q != IDLE);
    assign any_req  = req0_valid | req1_valid;
    assign timeout  = serving & (cnt_q == TO_LAST) & ~mem_ready;
    assign complete = serving & (mem_ready | timeout);

`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;

    // last_q = 1 means req1 was granted last, so req0 wins the next contention.
    always_comb begin
        grant1 = req1_valid & (~req0_valid | ~last_q);
        last_d = last_q;
        if (state_q == IDLE && any_req) begin
            last_d = grant1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant1 = req1_valid & ~req0_valid;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:           if (any_req) state_d = grant1 ? SERVE1 : SERVE0;
            SERVE0, SERVE1: if (complete) state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = serving ? cnt_q + 8'd1 : 8'd0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        if (state_q == IDLE && any_req) begin
            we_d    = grant1 ? req1_we    : req0_we;
            addr_d  = grant1 ? req1_addr  : req0_addr;
            wdata_d = grant1 ? req1_wdata : req0_wdata;
            mask_d  = grant1 ? req1_mask  : req0_mask;
        end
        done0_d = complete & (state_q == SERVE0);
        done1_d = complete & (state_q == SERVE1);
        err0_d  = timeout & (state_q == SERVE0);
        err1_d  = timeout & (state_q == SERVE1);
        rdata_d = rdata_q;
        if (serving && mem_ready) begin
            rdata_d = mem_rdata;
        end else if (timeout) begin
            rdata_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory port is driven only from the latched request and is quiet outside SERVE.
    always_comb begin
        busy       = serving;
        mem_cs     = serving;
        mem_we     = serving & we_q;
        mem_addr   = serving ? addr_q  : 32'd0;
        mem_wdata  = serving ? wdata_q : 32'd0;
        mem_mask   = serving ? mask_q  : 4'd0;
        req0_done  = done0_q;
        req1_done  = done1_q;
        req0_err   = err0_q;
        req1_err   = err1_q;
        resp_rdata = rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: transaction-level reference model plus directed literal scenarios.
module tb_dmem_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
    logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
    logic [3:0]  req0_mask = 0, req1_mask = 0;
    logic        req0_done, req0_err, req1_done, req1_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic        mem_cs, mem_we, busy;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata = 0;
    logic        mem_ready = 0;

    int tests = 0;
    int fails = 0;

    dmem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_mask(req0_mask), .req0_done(req0_done), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_mask(req1_mask), .req1_done(req1_done), .req1_err(req1_err),
        .resp_rdata(resp_rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cs"}, 32'(mem_cs), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_we"}, 32'(mem_we), 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_mask"}, 32'(mem_mask), 0);
        check({tag, "_done0"}, 32'(req0_done), 0);
        check({tag, "_done1"}, 32'(req1_done), 0);
        check({tag, "_err0"}, 32'(req0_err), 0);
        check({tag, "_err1"}, 32'(req1_err), 0);
        check({tag, "_rdata"}, resp_rdata, 0);
    endtask

    // Reference model: one outstanding transaction, owner -1 when idle.
    int          m_owner = -1;
    int          m_elapsed = 0;
    int          m_last = 1;
    bit [1:0]    m_done = 0, m_err = 0;
    logic [31:0] m_rdata = 0, m_addr = 0, m_wdata = 0;
    logic [3:0]  m_mask = 0;
    bit          m_we = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_owner = -1; m_elapsed = 0; m_last = 1; m_done = 0; m_err = 0;
            m_rdata = 0; m_addr = 0; m_wdata = 0; m_mask = 0; m_we = 0;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (m_owner >= 0) begin
                m_elapsed++;
                if (mem_ready) begin
                    m_rdata = mem_rdata;
                    m_done[m_owner] = 1'b1;
                    m_owner = -1;
                end else if (m_elapsed == TO) begin
                    m_rdata = 0;
                    m_done[m_owner] = 1'b1;
                    m_err[m_owner]  = 1'b1;
                    m_owner = -1;
                end
            end else if (req0_valid || req1_valid) begin
                int w;
                if (req0_valid && req1_valid) begin
`ifdef DMEM_ARB_RR_EN
                    w = 1 - m_last;
`else
                    w = 0;
`endif
                end else begin
                    w = req1_valid ? 1 : 0;
                end
                m_last    = w;
                m_owner   = w;
                m_elapsed = 0;
                m_we      = (w == 1) ? req1_we    : req0_we;
                m_addr    = (w == 1) ? req1_addr  : req0_addr;
                m_wdata   = (w == 1) ? req1_wdata : req0_wdata;
                m_mask    = (w == 1) ? req1_mask  : req0_mask;
            end
        end
    end

    // Single compare process, sampling on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst === 1'b1) begin
            check("m_busy", 32'(busy), 32'(m_owner >= 0));
            check("m_cs", 32'(mem_cs), 32'(m_owner >= 0));
            if (m_owner >= 0) begin
                check("m_we", 32'(mem_we), 32'(m_we));
                check("m_addr", mem_addr, m_addr);
                check("m_wdata", mem_wdata, m_wdata);
                check("m_mask", 32'(mem_mask), 32'(m_mask));
            end
            check("m_done0", 32'(req0_done), 32'(m_done[0]));
            check("m_done1", 32'(req1_done), 32'(m_done[1]));
            check("m_err0", 32'(req0_err), 32'(m_err[0]));
            check("m_err1", 32'(req1_err), 32'(m_err[1]));
            if (m_done != 0) check("m_rdata", resp_rdata, m_rdata);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("rst");
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0; req0_we = 0; req1_we = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    initial begin
        int n, cs_cnt;
        bit got;
        int g[4];
        int exp_g[4];
        int rdy_pct;

        repeat (2) @(negedge clk);
        check_all_zero("por");
        @(negedge clk);
        rst = 1'b1;

        // Single load, ready on first SERVE cycle.
        @(negedge clk);
        req0_valid = 1; req0_we = 0; req0_addr = 32'h100; req0_mask = 4'hF;
        @(negedge clk);
        check("ld_cs", 32'(mem_cs), 1);
        check("ld_addr", mem_addr, 32'h100);
        check("ld_we", 32'(mem_we), 0);
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("ld_done", 32'(req0_done), 1);
        check("ld_rdata", resp_rdata, 32'hDEADBEEF);
        check("ld_err", 32'(req0_err), 0);
        req0_valid = 0; mem_ready = 0;

        // Store with no memory response: timeout abort.
        @(negedge clk);
        req1_valid = 1; req1_we = 1; req1_addr = 32'h200; req1_wdata = 32'h55AA; req1_mask = 4'h3;
        cs_cnt = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (mem_cs) begin
                cs_cnt++;
                if (cs_cnt == 1) begin
                    check("to_addr", mem_addr, 32'h200);
                    check("to_wdata", mem_wdata, 32'h55AA);
                    check("to_mask", 32'(mem_mask), 32'h3);
                    check("to_we", 32'(mem_we), 1);
                end
            end
            if (req1_done) begin
                got = 1;
                check("to_err", 32'(req1_err), 1);
                check("to_rdata", resp_rdata, 0);
                check("to_done0", 32'(req0_done), 0);
                check("to_cs_low", 32'(mem_cs), 0);
            end
        end
        check("to_seen", 32'(got), 1);
        check("to_cs_cycles", cs_cnt, TO);
        req1_valid = 0;

        // Contention from reset.
        do_reset();
        @(negedge clk);
        req0_valid = 1; req0_we = 0; req0_addr = 32'h1000;
        req1_valid = 1; req1_we = 0; req1_addr = 32'h2000;
        mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (req0_done) begin g[n] = 0; n++; end
            else if (req1_done) begin g[n] = 1; n++; end
        end
        clear_inputs();
`ifdef DMEM_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        check("arb_count", n, 4);
        for (int i = 0; i < 4; i++) check($sformatf("arb_grant%0d", i), g[i], exp_g[i]);

        // Reset in the middle of SERVE0.
        @(negedge clk);
        req0_valid = 1; req0_addr = 32'h400;
        @(negedge clk);
        check("mr_cs", 32'(mem_cs), 1);
        #2 rst = 1'b0;
        #1 check_all_zero("mr");
        req0_valid = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mr_nodone", 32'(req0_done), 0);
            check("mr_idle", 32'(busy), 0);
        end

        // Live address change during SERVE0 must not leak to the memory port.
        @(negedge clk);
        req0_valid = 1; req0_we = 0; req0_addr = 32'h300;
        @(negedge clk);
        check("hold_addr0", mem_addr, 32'h300);
        req0_addr = 32'hABC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_addr", mem_addr, 32'h300);
            check("hold_cs", 32'(mem_cs), 1);
        end
        mem_ready = 1; mem_rdata = 32'h12345678;
        @(negedge clk);
        check("hold_done", 32'(req0_done), 1);
        check("hold_rdata", resp_rdata, 32'h12345678);
        clear_inputs();

        // Random traffic: moderate, sparse and absent memory responses.
        for (int ph = 0; ph < 3; ph++) begin
            rdy_pct = (ph == 0) ? 50 : (ph == 1) ? 3 : 0;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                req0_valid = ($urandom_range(99) < 60);
                req1_valid = ($urandom_range(99) < 60);
                req0_we = $urandom_range(1); req1_we = $urandom_range(1);
                req0_addr = $urandom; req1_addr = $urandom;
                req0_wdata = $urandom; req1_wdata = $urandom;
                req0_mask = 4'($urandom); req1_mask = 4'($urandom);
                mem_rdata = $urandom;
                mem_ready = ($urandom_range(99) < rdy_pct);
            end
        end
        clear_inputs();
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
